// File: rtl/fuzzy_frame_tx.sv
// fuzzy_frame_tx: buffers sample bytes and frames them onto ss/data_bus,
// then captures the risk core's result after a fixed response latency.
module fuzzy_frame_tx #(
  parameter int         NUM_BYTES    = 4,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         RESP_LATENCY = 3,
  parameter int         GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ss,
  output logic [7:0] data_bus,
  input  logic [7:0] risk_in,
  output logic [7:0] risk_out,
  output logic       risk_valid,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int T1 = (NUM_BYTES > RESP_LATENCY) ? NUM_BYTES : RESP_LATENCY;
  localparam int T2 = (T1 > GAP_CYCLES) ? T1 : GAP_CYCLES;
  localparam int TW = (T2 > 1) ? $clog2(T2) : 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    WAIT_RESP,
    CAPTURE,
    GAP
  } state_t;

  state_t        state;
  state_t        state_d;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;
  logic [7:0]    bus_d;

  assign push    = in_valid & in_ready;
  assign pop     = (state == PAYLOAD);
  assign rd_nxt  = rd_ptr + AW'(1);
  assign count_d = count + CW'(push) - CW'(pop);

  // Next state, per-state timer and the byte to drive next cycle.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (count >= CW'(NUM_BYTES)) state_d = HDR;
      HDR:
        state_d = PAYLOAD;
      PAYLOAD:
        if (int'(tmr) == NUM_BYTES - 1)
          state_d = (RESP_LATENCY == 1) ? CAPTURE : WAIT_RESP;
      WAIT_RESP:
        if (int'(tmr) == RESP_LATENCY - 2) state_d = CAPTURE;
      CAPTURE:
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:
        if (int'(tmr) == GAP_CYCLES - 1) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
    tmr_d = (state_d != state) ? '0 : tmr + TW'(1);
    // Head advances one entry per PAYLOAD cycle, so look one ahead.
    bus_d = 8'h00;
    if (state_d == HDR)
      bus_d = HEADER;
    else if (state_d == PAYLOAD)
      bus_d = (state == PAYLOAD) ? mem[rd_nxt] : mem[rd_ptr];
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_d;
      tmr   <= tmr_d;
    end
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      count    <= count_d;
      in_ready <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  // Registered core-facing and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss         <= 1'b0;
      data_bus   <= 8'h00;
      risk_out   <= 8'h00;
      risk_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ss         <= (state_d == HDR) || (state_d == PAYLOAD);
      data_bus   <= bus_d;
      busy       <= (state_d != IDLE);
      risk_valid <= (state == CAPTURE);
      if (state == CAPTURE) risk_out <= risk_in;
    end
  end

endmodule

// File: tb/tb_fuzzy_frame_tx.sv
// tb_fuzzy_frame_tx: directed table, corner sequences and random traffic
// checked every cycle against a frame-timeline reference model.
module tb_fuzzy_frame_tx;

  localparam int         N   = 4;
  localparam int         D   = 8;
  localparam int         R   = 3;
  localparam int         G   = 2;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] risk_in  = 8'h00;
  logic       in_ready;
  logic       ss;
  logic [7:0] data_bus;
  logic [7:0] risk_out;
  logic       risk_valid;
  logic       busy;

  fuzzy_frame_tx #(
    .NUM_BYTES(N),
    .FIFO_DEPTH(D),
    .HEADER(HDR),
    .RESP_LATENCY(R),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ss(ss),
    .data_bus(data_bus),
    .risk_in(risk_in),
    .risk_out(risk_out),
    .risk_valid(risk_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: FIFO as a queue, the frame as a timeline anchored at fs
  // (the header cycle); every output follows from offset cyc - fs.
  logic [7:0] q[$];
  int         cyc   = 0;
  int         fs    = -1000;
  logic [7:0] m_ro  = 8'h00;
  bit         known = 0;

  logic       s_ss, s_rv, s_busy, s_rdy;
  logic [7:0] s_db, s_ro;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] r;
    logic       e_ss;
    logic [7:0] e_db;
    logic       e_busy;
    logic       e_rv;
    logic [7:0] e_ro;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%02h want=%02h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int         o;
    logic       e_ss;
    logic [7:0] e_db;
    if (!known) return;
    o    = cyc - fs;
    e_ss = (o >= 0 && o <= N);
    e_db = 8'h00;
    if (o == 0) e_db = HDR;
    else if (e_ss && q.size() > 0) e_db = q[0];
    chk("ss", 8'(s_ss), 8'(e_ss));
    chk("data_bus", s_db, e_db);
    chk("busy", 8'(s_busy), 8'(o >= 0 && o <= N + R + G));
    chk("risk_valid", 8'(s_rv), 8'(o == N + R + 1));
    chk("risk_out", s_ro, m_ro);
    chk("in_ready", 8'(s_rdy), 8'(q.size() < D));
  endtask

  task automatic model_step(input logic v, input logic [7:0] d,
                            input logic [7:0] r, input logic rs);
    int o;
    int sz;
    if (rs) begin
      q.delete();
      fs    = cyc - 1000;
      m_ro  = 8'h00;
      known = 1;
    end else if (known) begin
      o  = cyc - fs;
      sz = q.size();
      if (o == N + R) m_ro = r;
      if (o > N + R + G && sz >= N) fs = cyc + 1;
      if (o >= 1 && o <= N) void'(q.pop_front());
      if (v && sz < D) q.push_back(d);
    end
    cyc++;
  endtask

  task automatic tick(input logic v, input logic [7:0] d,
                      input logic [7:0] r, input logic rs);
    in_valid = v;
    in_data  = d;
    risk_in  = r;
    rst      = rs;
    @(negedge clk);
    s_ss   = ss;
    s_db   = data_bus;
    s_rv   = risk_valid;
    s_busy = busy;
    s_rdy  = in_ready;
    s_ro   = risk_out;
    model_check();
    model_step(v, d, r, rs);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int         wins;
    int         low;
    int         gap;
    int         pulses;
    bit         prev;
    bit         found;
    bit         saw_full;
    logic [7:0] got[$];
    logic [7:0] want[5];

    for (int i = 0; i < 16; i++) begin
      tv[i].v      = (i < 4);
      tv[i].d      = (i < 4) ? 8'(16 * (i + 1)) : 8'h00;
      tv[i].r      = 8'h5C;
      tv[i].e_ss   = (i >= 5 && i <= 9);
      tv[i].e_db   = 8'h00;
      tv[i].e_busy = (i >= 5 && i <= 14);
      tv[i].e_rv   = (i == 13);
      tv[i].e_ro   = (i >= 13) ? 8'h5C : 8'h00;
    end
    tv[5].e_db = 8'hA5;
    tv[6].e_db = 8'h10;
    tv[7].e_db = 8'h20;
    tv[8].e_db = 8'h30;
    tv[9].e_db = 8'h40;

    tick(1'b0, 8'h00, 8'h00, 1'b1);

    for (int i = 0; i < 16; i++) begin
      tick(tv[i].v, tv[i].d, tv[i].r, 1'b0);
      chk($sformatf("tv%0d_ss", i), 8'(s_ss), 8'(tv[i].e_ss));
      chk($sformatf("tv%0d_db", i), s_db, tv[i].e_db);
      chk($sformatf("tv%0d_busy", i), 8'(s_busy), 8'(tv[i].e_busy));
      chk($sformatf("tv%0d_rv", i), 8'(s_rv), 8'(tv[i].e_rv));
      chk($sformatf("tv%0d_ro", i), s_ro, tv[i].e_ro);
      chk($sformatf("tv%0d_rdy", i), 8'(s_rdy), 8'h01);
    end

    // Three bytes never start a frame; the fourth starts one 2 cycles on.
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h21 + i), 8'h00, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("three_busy", 8'(s_busy), 8'h00);
    chk("three_ss", 8'(s_ss), 8'h00);
    tick(1'b1, 8'h24, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("start_plus1_ss", 8'(s_ss), 8'h00);
    tick(1'b0, 8'h00, 8'h00, 1'b0);
    chk("start_plus2_ss", 8'(s_ss), 8'h01);
    chk("start_plus2_db", s_db, HDR);
    for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);

    // Nine bytes: two back-to-back frames with a fixed low gap.
    wins = 0;
    low  = 0;
    gap  = -1;
    prev = 0;
    for (int i = 0; i < 49; i++) begin
      if (i < 9) tick(1'b1, 8'(8'h80 + i), 8'h00, 1'b0);
      else tick(1'b0, 8'h00, 8'h00, 1'b0);
      if (s_ss && !prev) begin
        wins++;
        if (wins == 2) gap = low;
      end
      if (s_ss) low = 0;
      else low++;
      prev = s_ss;
    end
    chk("two_frames", 8'(wins), 8'd2);
    chk("frame_gap", 8'(gap), 8'(R + 1 + G));

    // Continuous pushes fill the FIFO and must be refused while full.
    saw_full = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 8'(8'hC0 + i), 8'h00, 1'b0);
      if (!s_rdy) saw_full = 1;
    end
    chk("fifo_full_seen", 8'(saw_full), 8'h01);
    for (int i = 0; i < 40; i++) tick(1'b0, 8'h00, 8'h00, 1'b0);

    // Reset during the third payload byte.
    tick(1'b0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h01 + i), 8'h00, 1'b0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 8'h00, 8'h77, 1'b0);
      if (s_ss && s_db == 8'h02) begin
        found = 1;
        break;
      end
    end
    chk("find_byte2", 8'(found), 8'h01);
    tick(1'b0, 8'h00, 8'h77, 1'b1);
    chk("rst_cycle_db", s_db, 8'h03);
    tick(1'b0, 8'h00, 8'h77, 1'b0);
    chk("post_rst_ss", 8'(s_ss), 8'h00);
    chk("post_rst_db", s_db, 8'h00);
    chk("post_rst_rdy", 8'(s_rdy), 8'h01);
    chk("post_rst_ro", s_ro, 8'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 8'h77, 1'b0);
      if (s_rv) pulses++;
    end
    chk("post_rst_no_rv", 8'(pulses), 8'h00);

    want[0] = HDR;
    want[1] = 8'h61;
    want[2] = 8'h62;
    want[3] = 8'h63;
    want[4] = 8'h64;
    got.delete();
    for (int i = 0; i < 24; i++) begin
      if (i < 4) tick(1'b1, 8'(8'h61 + i), 8'h00, 1'b0);
      else tick(1'b0, 8'h00, 8'h00, 1'b0);
      if (s_ss) got.push_back(s_db);
    end
    chk("fresh_len", 8'(got.size()), 8'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("fresh_b%0d", i),
          (i < got.size()) ? got[i] : 8'hxx, want[i]);

    // Toggling risk_in: only the capture-cycle value may land.
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tick((i < 4), 8'(8'h31 + i), (cyc % 2) ? 8'hFF : 8'h00, 1'b0);
      if (s_rv) pulses++;
    end
    chk("toggle_pulses", 8'(pulses), 8'd1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++)
      tick(($urandom_range(0, 99) < 55), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 399) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
